// File: rtl/noc_params_pkg.sv
// noc_params_pkg: shared flit label, port and input-state types for the router
package noc_params_pkg;
  localparam int LABEL_SIZE = 2;
  typedef enum logic [1:0] {HEAD = 2'b00, BODY = 2'b01, TAIL = 2'b10, HEADTAIL = 2'b11} flit_label_t;
  typedef enum logic [2:0] {LOCAL = 3'd0, NORTH = 3'd1, SOUTH = 3'd2, WEST = 3'd3, EAST = 3'd4} port_t;
  typedef enum logic [1:0] {IDLE, VA, ACTIVE} input_state_t;
  function automatic logic is_head(flit_label_t l);
    return l == HEAD || l == HEADTAIL;
  endfunction
  function automatic logic is_tail(flit_label_t l);
    return l == TAIL || l == HEADTAIL;
  endfunction
endpackage

// File: rtl/rc_unit.sv
// rc_unit: combinational XY dimension-order route computation
module rc_unit
  import noc_params_pkg::*;
#(
  parameter int COORD_SIZE = 2,
  parameter int X_CURRENT  = 0,
  parameter int Y_CURRENT  = 0
) (
  input  logic [COORD_SIZE-1:0] x_dest,
  input  logic [COORD_SIZE-1:0] y_dest,
  output port_t                 port
);
  localparam logic [COORD_SIZE-1:0] XC = COORD_SIZE'(X_CURRENT);
  localparam logic [COORD_SIZE-1:0] YC = COORD_SIZE'(Y_CURRENT);
  // resolve X first, then Y, otherwise deliver locally
  always_comb
    port = x_dest > XC ? EAST :
           x_dest < XC ? WEST :
           y_dest > YC ? SOUTH :
           y_dest < YC ? NORTH : LOCAL;
endmodule

// File: rtl/input_port_ctrl.sv
// input_port_ctrl: per-port packet controller (route, VA/SA request, flit forward, credits)
module input_port_ctrl
  import noc_params_pkg::*;
#(
  parameter int FLIT_SIZE  = 16,
  parameter int COORD_SIZE = 2,
  parameter int X_CURRENT  = 0,
  parameter int Y_CURRENT  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_SIZE-1:0] fifo_data_i,
  input  logic                 fifo_empty_i,
  output logic                 fifo_read_o,
  output logic                 va_req_o,
  input  logic                 va_grant_i,
  output logic                 sa_req_o,
  input  logic                 sa_grant_i,
  output logic [2:0]           out_port_o,
  output logic [FLIT_SIZE-1:0] flit_o,
  output logic                 flit_valid_o,
  output logic                 credit_o,
  output logic                 error_o
);
  flit_label_t  label;
  port_t        route;
  input_state_t state, state_n;
  logic         first_q, pop, drop, stray_head;
  assign label = flit_label_t'(fifo_data_i[FLIT_SIZE-1 -: LABEL_SIZE]);
  rc_unit #(.COORD_SIZE(COORD_SIZE), .X_CURRENT(X_CURRENT), .Y_CURRENT(Y_CURRENT)) u_rc (
    .x_dest(fifo_data_i[FLIT_SIZE-LABEL_SIZE-1 -: COORD_SIZE]),
    .y_dest(fifo_data_i[FLIT_SIZE-LABEL_SIZE-COORD_SIZE-1 -: COORD_SIZE]),
    .port  (route)
  );
  // next state, requests and pop/drop decisions
  always_comb begin
    state_n  = state;
    va_req_o = 1'b0;
    sa_req_o = 1'b0;
    pop      = 1'b0;
    drop     = 1'b0;
    case (state)
      IDLE: if (!fifo_empty_i) begin
        if (is_head(label)) state_n = VA;
        else drop = 1'b1;
      end
      VA: begin
        va_req_o = 1'b1;
        if (va_grant_i) state_n = ACTIVE;
      end
      ACTIVE: begin
        sa_req_o = !fifo_empty_i;
        pop      = sa_req_o && sa_grant_i;
        if (pop && is_tail(label)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  assign fifo_read_o = pop || drop;
  // a plain HEAD after the packet's first flit is a protocol violation
  assign stray_head  = pop && !first_q && label == HEAD;
  // state, route latch, forwarded flit, credit pulse and sticky error
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state        <= IDLE;
      out_port_o   <= LOCAL;
      flit_o       <= '0;
      flit_valid_o <= 1'b0;
      credit_o     <= 1'b0;
      error_o      <= 1'b0;
      first_q      <= 1'b0;
    end else begin
      state        <= state_n;
      flit_valid_o <= pop;
      credit_o     <= fifo_read_o;
      error_o      <= error_o || drop || stray_head;
      first_q      <= state == VA ? 1'b1 : pop ? 1'b0 : first_q;
      if (state == IDLE && state_n == VA) out_port_o <= route;
      if (pop) flit_o <= stray_head ? {BODY, fifo_data_i[FLIT_SIZE-LABEL_SIZE-1:0]} : fifo_data_i;
    end
endmodule
